bc_input_port: RTL and testbench

- Upstream input device interface for the Basic Computer.
- Receives 8N1 asynchronous serial characters on `rx` and deposits each completed byte into INPR.
- Raises FGI to the controller. When the controller executes INP, it pulses `clr_FGI`, which clears FGI.
- Flags characters lost to overrun or to framing errors.

---
 rtl/bc_input_port_if.sv | 21 ++
 rtl/bc_input_port.sv | 127 ++++++++++++
 tb/tb_bc_input_port.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/bc_input_port_if.sv
// Signal bundle between the Basic Computer controller and its serial input port.
interface bc_input_port_if;
    logic       rx;
    logic       clr_FGI;
    logic       clr_err;
    logic [7:0] INPR;
    logic       FGI;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    modport master (
        output rx, clr_FGI, clr_err,
        input  INPR, FGI, overrun, frame_err, busy
    );

    modport slave (
        input  rx, clr_FGI, clr_err,
        output INPR, FGI, overrun, frame_err, busy
    );
endinterface

// File: rtl/bc_input_port.sv
// 8N1 serial receiver feeding INPR/FGI of the Basic Computer, with sticky overrun and framing flags.
//
// state       | meaning
// S_IDLE      | line idle, waiting for a low rx_s
// S_START     | timing to mid start bit to reject glitches
// S_DATA      | sampling 8 data bits LSB first, one per bit time
// S_STOP      | timing to mid stop bit, then accept or flag framing error
// S_WAIT_IDLE | after a bad stop bit, hold off until the line returns high
module bc_input_port #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input logic            clk,
    input logic            rst,
    bc_input_port_if.slave bus
);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_STOP      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;

    localparam logic [CNT_W-1:0] HALF_TC = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_TC  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_m, rx_s;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       inpr;
    logic             fgi, ovr, ferr;
    logic             complete, stop_bad;

    assign complete = (state == S_STOP) && (cnt == BIT_TC) && rx_s;
    assign stop_bad = (state == S_STOP) && (cnt == BIT_TC) && !rx_s;

    // Synchronizer resets to the idle-line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (cnt == HALF_TC) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? S_IDLE : S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (cnt == BIT_TC) begin
                        cnt            <= '0;
                        shift[bit_idx] <= rx_s;
                        if (bit_idx == 3'd7) state <= S_STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (cnt == BIT_TC) begin
                        cnt   <= '0;
                        state <= rx_s ? S_IDLE : S_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Later assignments win, so an error event beats a coincident clr_err.
    always_ff @(posedge clk) begin
        if (rst) begin
            inpr <= 8'h00;
            fgi  <= 1'b0;
            ovr  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (bus.clr_err) begin
                ovr  <= 1'b0;
                ferr <= 1'b0;
            end
            if (complete) begin
                if (!fgi || bus.clr_FGI) begin
                    inpr <= shift;
                    fgi  <= 1'b1;
                end else begin
                    ovr <= 1'b1;
                end
            end else if (bus.clr_FGI) begin
                fgi <= 1'b0;
            end
            if (stop_bad) ferr <= 1'b1;
        end
    end

    assign bus.INPR      = inpr;
    assign bus.FGI       = fgi;
    assign bus.overrun   = ovr;
    assign bus.frame_err = ferr;
    assign bus.busy      = (state != S_IDLE);
endmodule

// File: tb/tb_bc_input_port.sv
// Bench for bc_input_port: fixed vector table, hand-written corner sequences, random frames vs a flag-level model.
module tb_bc_input_port;
    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bc_input_port_if bus ();

    bc_input_port #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: what the controller should see, updated per frame from the port's rules.
    logic [7:0] m_inpr;
    logic       m_fgi, m_ovr, m_ferr;

    typedef struct {
        logic [7:0] d;
        logic       stop;
        logic       cb;
        logic       ce;
        logic       cerr;
        int         hold;
        logic [7:0] e_inpr;
        logic       e_fgi;
        logic       e_ovr;
        logic       e_ferr;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [7:0] e_inpr, input logic e_fgi,
                                 input logic e_ovr, input logic e_ferr);
        check({tag, ".INPR"}, bus.INPR, e_inpr);
        check({tag, ".FGI"}, {7'd0, bus.FGI}, {7'd0, e_fgi});
        check({tag, ".overrun"}, {7'd0, bus.overrun}, {7'd0, e_ovr});
        check({tag, ".frame_err"}, {7'd0, bus.frame_err}, {7'd0, e_ferr});
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_clr_fgi();
        bus.clr_FGI = 1'b1;
        @(negedge clk);
        bus.clr_FGI = 1'b0;
    endtask

    task automatic pulse_clr_err();
        bus.clr_err = 1'b1;
        @(negedge clk);
        bus.clr_err = 1'b0;
    endtask

    // Plays one 10-bit frame; ce pulses clr_FGI on the mid-stop-bit edge (posedge 155 after the start drive).
    task automatic send_frame(input logic [7:0] d, input logic stop, input logic ce,
                              input int hold, output int lat);
        lat = -1;
        for (int c = 0; c < 10 * CPB; c++) begin
            int b;
            b = c / CPB;
            if (b == 0) bus.rx = 1'b0;
            else if (b <= 8) bus.rx = d[b-1];
            else bus.rx = stop;
            bus.clr_FGI = (ce && c == 154);
            @(negedge clk);
            if (lat < 0 && bus.FGI) lat = c + 1;
        end
        bus.clr_FGI = 1'b0;
        if (!stop) begin
            bus.rx = 1'b0;
            cycles(hold);
            check("break_busy", {7'd0, bus.busy}, 8'd1);
            bus.rx = 1'b1;
            cycles(6);
        end else begin
            bus.rx = 1'b1;
        end
        check("post_frame_busy", {7'd0, bus.busy}, 8'd0);
    endtask

    task automatic model_frame(input logic [7:0] d, input logic stop, input logic cb,
                               input logic ce, input logic cerr);
        if (cb) m_fgi = 1'b0;
        if (cerr) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
        if (stop) begin
            if (!m_fgi || ce) begin
                m_inpr = d;
                m_fgi  = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else begin
            m_ferr = 1'b1;
            if (ce) m_fgi = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] d, input logic stop, input logic cb,
                             input logic ce, input logic cerr, input int hold);
        int lat;
        if (cb) pulse_clr_fgi();
        if (cerr) pulse_clr_err();
        send_frame(d, stop, ce, hold, lat);
        model_frame(d, stop, cb, ce, cerr);
    endtask

    initial begin
        int lat;
        int idle_bad;
        tbl[0] = '{8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 0,  8'h3C, 1'b1, 1'b0, 1'b0};
        tbl[1] = '{8'hC3, 1'b1, 1'b0, 1'b0, 1'b0, 0,  8'h3C, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{8'h11, 1'b1, 1'b1, 1'b0, 1'b1, 0,  8'h11, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{8'h22, 1'b1, 1'b0, 1'b1, 1'b0, 0,  8'h22, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{8'h7E, 1'b0, 1'b1, 1'b0, 1'b0, 40, 8'h22, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{8'h99, 1'b1, 1'b0, 1'b0, 1'b0, 0,  8'h99, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{8'h42, 1'b1, 1'b1, 1'b0, 1'b1, 0,  8'h42, 1'b1, 1'b0, 1'b0};

        bus.rx      = 1'b1;
        bus.clr_FGI = 1'b0;
        bus.clr_err = 1'b0;
        rst         = 1'b1;
        cycles(3);
        rst = 1'b0;
        check_outputs("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.busy", {7'd0, bus.busy}, 8'd0);

        idle_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.INPR !== 8'h00 || bus.FGI !== 1'b0 || bus.overrun !== 1'b0 ||
                bus.frame_err !== 1'b0 || bus.busy !== 1'b0) idle_bad++;
        end
        check("idle_cycles_disturbed", idle_bad[7:0], 8'd0);

        // Single byte with latency measurement, then an INP clear.
        send_frame(8'hA5, 1'b1, 1'b0, 0, lat);
        check_outputs("a5", 8'hA5, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (lat < 153 || lat > 155) begin
            n_bad++;
            $display("FAIL a5_latency: got %0d cycles expected 154 +/-1", lat);
        end
        pulse_clr_fgi();
        cycles(2);
        check_outputs("a5_cleared", 8'hA5, 1'b0, 1'b0, 1'b0);
        m_inpr = 8'hA5;
        m_fgi  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;

        for (int i = 0; i < 7; i++) begin
            run_frame(tbl[i].d, tbl[i].stop, tbl[i].cb, tbl[i].ce, tbl[i].cerr, tbl[i].hold);
            check_outputs($sformatf("tbl%0d", i), tbl[i].e_inpr, tbl[i].e_fgi,
                          tbl[i].e_ovr, tbl[i].e_ferr);
        end

        // Short low glitch: receiver starts, rejects at mid start bit, nothing changes.
        bus.rx = 1'b0;
        cycles(4);
        bus.rx = 1'b1;
        cycles(1);
        check("glitch_busy_rise", {7'd0, bus.busy}, 8'd1);
        cycles(9);
        check("glitch_busy_fall", {7'd0, bus.busy}, 8'd0);
        check_outputs("glitch", m_inpr, m_fgi, m_ovr, m_ferr);

        // Reset in the middle of data bit 4 of an 8'hFF frame.
        pulse_clr_err();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        bus.rx = 1'b0;
        cycles(CPB);
        bus.rx = 1'b1;
        cycles(5 * CPB - CPB + 8);
        check("midframe_busy", {7'd0, bus.busy}, 8'd1);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
        check_outputs("midframe_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("midframe_rst.busy", {7'd0, bus.busy}, 8'd0);
        cycles(80);
        check("midframe_quiet.busy", {7'd0, bus.busy}, 8'd0);
        m_inpr = 8'h00;
        m_fgi  = 1'b0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        run_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check_outputs("after_rst_5a", 8'h5A, 1'b1, 1'b0, 1'b0);

        // Random back-to-back frames against the model.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] d;
            logic       stop, cb, ce, cerr;
            d    = 8'($urandom_range(0, 255));
            stop = ($urandom_range(0, 4) != 0);
            cb   = 1'($urandom_range(0, 1));
            ce   = ($urandom_range(0, 3) == 0);
            cerr = ($urandom_range(0, 3) == 0);
            run_frame(d, stop, cb, ce, cerr, int'($urandom_range(20, 60)));
            check_outputs($sformatf("rnd%0d", i), m_inpr, m_fgi, m_ovr, m_ferr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
